// File: rtl/calc_sequencer_if.sv
// Keypad/ALU/display signal bundle for the calculator sequencer.
// Latency: none, wires only.
// Backpressure: none; key and ALU strobes are single-cycle pulses.
interface calc_sequencer_if;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        alu_done;
   logic [13:0] alu_result;
   logic        alu_neg;
   logic        alu_start;
   logic [6:0]  opnd_a;
   logic [6:0]  opnd_b;
   logic [1:0]  op_sel;
   logic [1:0]  mode;
   logic [13:0] disp_val;
   logic        disp_neg;
   logic        busy;
   logic        err;

   // Sequencer side: consumes keys and ALU results, drives operands/display.
   modport master (
      input  key_valid, key_code, alu_done, alu_result, alu_neg,
      output alu_start, opnd_a, opnd_b, op_sel, mode, disp_val, disp_neg, busy, err
   );

   // Environment side: keypad decoder, ALU and display mux.
   modport slave (
      output key_valid, key_code, alu_done, alu_result, alu_neg,
      input  alu_start, opnd_a, opnd_b, op_sel, mode, disp_val, disp_neg, busy, err
   );
endinterface

// File: rtl/calc_sequencer.sv
// Keypad-driven two-operand calculator sequencer with ALU start/done handshake.
// Latency: a key sampled at edge N is visible after edge N; alu_start follows Enter by one cycle.
// Backpressure: none; keys outside the accepting states are dropped, ALU wait bounded by TIMEOUT_CYCLES.
module calc_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   calc_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      ST_ENTER_A = 2'd0,
      ST_ENTER_B = 2'd1,
      ST_EXEC    = 2'd2,
      ST_SHOW    = 2'd3
   } state_t;

   localparam logic [16:0] TMO_LIM = 17'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic [6:0]  opnd_a_q, opnd_a_d;
   logic [6:0]  opnd_b_q, opnd_b_d;
   logic [1:0]  cnt_a_q, cnt_a_d;
   logic [1:0]  cnt_b_q, cnt_b_d;
   logic [1:0]  op_sel_q, op_sel_d;
   logic [13:0] res_q, res_d;
   logic        res_neg_q, res_neg_d;
   logic        err_q, err_d;
   logic        alu_start_q, alu_start_d;
   logic [15:0] tmo_q, tmo_d;

   logic        k_digit, k_op, k_enter, k_clear;
   logic [1:0]  k_op_sel;
   logic        tmo_hit;
   logic        res_small;
   logic [13:0] disp_val_c;
   logic        disp_neg_c;

   // Key decode; code 15 falls in no class and is therefore ignored everywhere.
   assign k_digit  = bus.key_valid && (bus.key_code <= 4'd9);
   assign k_op     = bus.key_valid && (bus.key_code >= 4'd10) && (bus.key_code <= 4'd12);
   assign k_enter  = bus.key_valid && (bus.key_code == 4'd13);
   assign k_clear  = bus.key_valid && (bus.key_code == 4'd14);
   assign k_op_sel = 2'(bus.key_code - 4'd10);

   assign tmo_hit   = ({1'b0, tmo_q} + 17'd1) == TMO_LIM;
   assign res_small = !res_neg_q && (res_q <= 14'd99);

   // Decimal shift-in; caller guarantees old <= 9 so the result never exceeds 99.
   function automatic logic [6:0] acc_digit(input logic [6:0] old, input logic [3:0] d);
      return (old * 7'd10) + {3'b000, d};
   endfunction

   // State and datapath registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ENTER_A;
         opnd_a_q    <= '0;
         opnd_b_q    <= '0;
         cnt_a_q     <= '0;
         cnt_b_q     <= '0;
         op_sel_q    <= '0;
         res_q       <= '0;
         res_neg_q   <= 1'b0;
         err_q       <= 1'b0;
         alu_start_q <= 1'b0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         opnd_a_q    <= opnd_a_d;
         opnd_b_q    <= opnd_b_d;
         cnt_a_q     <= cnt_a_d;
         cnt_b_q     <= cnt_b_d;
         op_sel_q    <= op_sel_d;
         res_q       <= res_d;
         res_neg_q   <= res_neg_d;
         err_q       <= err_d;
         alu_start_q <= alu_start_d;
         tmo_q       <= tmo_d;
      end
   end

   // Next-state selection; in EXEC a clear beats a coincident alu_done.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_ENTER_A: if (k_op) state_d = ST_ENTER_B;
         ST_ENTER_B: begin
            if (k_clear)      state_d = ST_ENTER_A;
            else if (k_enter) state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (k_clear)                     state_d = ST_ENTER_A;
            else if (bus.alu_done || tmo_hit) state_d = ST_SHOW;
         end
         ST_SHOW: begin
            if (k_clear || k_digit)      state_d = ST_ENTER_A;
            else if (k_op && res_small)  state_d = ST_ENTER_B;
         end
         default: state_d = ST_ENTER_A;
      endcase
   end

   // Operand, operator, result, timeout and error updates per state.
   always_comb begin
      opnd_a_d    = opnd_a_q;
      opnd_b_d    = opnd_b_q;
      cnt_a_d     = cnt_a_q;
      cnt_b_d     = cnt_b_q;
      op_sel_d    = op_sel_q;
      res_d       = res_q;
      res_neg_d   = res_neg_q;
      err_d       = err_q;
      alu_start_d = 1'b0;
      tmo_d       = tmo_q;

      unique case (state_q)
         ST_ENTER_A: begin
            if (k_digit) begin
               err_d = 1'b0;
               if (cnt_a_q != 2'd2) begin
                  opnd_a_d = acc_digit(opnd_a_q, bus.key_code);
                  cnt_a_d  = cnt_a_q + 2'd1;
               end
            end else if (k_op) begin
               op_sel_d = k_op_sel;
               opnd_b_d = '0;
               cnt_b_d  = '0;
            end else if (k_clear) begin
               opnd_a_d = '0;
               cnt_a_d  = '0;
               err_d    = 1'b0;
            end
         end
         ST_ENTER_B: begin
            if (k_digit) begin
               err_d = 1'b0;
               if (cnt_b_q != 2'd2) begin
                  opnd_b_d = acc_digit(opnd_b_q, bus.key_code);
                  cnt_b_d  = cnt_b_q + 2'd1;
               end
            end else if (k_op) begin
               op_sel_d = k_op_sel;
            end else if (k_enter) begin
               alu_start_d = 1'b1;
               tmo_d       = '0;
            end else if (k_clear) begin
               opnd_a_d  = '0;
               opnd_b_d  = '0;
               cnt_a_d   = '0;
               cnt_b_d   = '0;
               op_sel_d  = '0;
               res_d     = '0;
               res_neg_d = 1'b0;
               err_d     = 1'b0;
            end
         end
         ST_EXEC: begin
            tmo_d = tmo_q + 16'd1;
            if (k_clear) begin
               opnd_a_d  = '0;
               opnd_b_d  = '0;
               cnt_a_d   = '0;
               cnt_b_d   = '0;
               op_sel_d  = '0;
               res_d     = '0;
               res_neg_d = 1'b0;
               err_d     = 1'b0;
            end else if (bus.alu_done) begin
               res_d     = bus.alu_result;
               res_neg_d = bus.alu_neg;
            end else if (tmo_hit) begin
               res_d     = '0;
               res_neg_d = 1'b0;
               err_d     = 1'b1;
            end
         end
         ST_SHOW: begin
            if (k_clear || k_digit) begin
               opnd_a_d  = k_digit ? {3'b000, bus.key_code} : 7'd0;
               cnt_a_d   = k_digit ? 2'd1 : 2'd0;
               opnd_b_d  = '0;
               cnt_b_d   = '0;
               op_sel_d  = '0;
               res_d     = '0;
               res_neg_d = 1'b0;
               err_d     = 1'b0;
            end else if (k_op && res_small) begin
               opnd_a_d = res_q[6:0];
               cnt_a_d  = 2'd2;
               op_sel_d = k_op_sel;
               opnd_b_d = '0;
               cnt_b_d  = '0;
            end
         end
         default: ;
      endcase
   end

   // Display source chosen from the registered state, so it changes only at clock edges.
   always_comb begin
      disp_val_c = 14'd0;
      disp_neg_c = 1'b0;
      unique case (state_q)
         ST_ENTER_A: disp_val_c = {7'd0, opnd_a_q};
         ST_ENTER_B,
         ST_EXEC:    disp_val_c = {7'd0, opnd_b_q};
         ST_SHOW: begin
            disp_val_c = res_q;
            disp_neg_c = res_neg_q;
         end
         default: ;
      endcase
   end

   assign bus.alu_start = alu_start_q;
   assign bus.opnd_a    = opnd_a_q;
   assign bus.opnd_b    = opnd_b_q;
   assign bus.op_sel    = op_sel_q;
   assign bus.mode      = state_q;
   assign bus.disp_val  = disp_val_c;
   assign bus.disp_neg  = disp_neg_c;
   assign bus.busy      = (state_q == ST_EXEC);
   assign bus.err       = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: key sequences, ALU handshake, timeout, clear and reset.
// Latency: inputs driven on the falling edge, outputs checked on the next falling edge.
// Backpressure: none; ALU responses are scripted pulses.
module tb_calc_sequencer;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   calc_sequencer_if sq_if ();

   calc_sequencer #(.TIMEOUT_CYCLES(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sq_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every output packed together; all-zero means the reset/cleared state.
   function automatic logic [37:0] all_outs();
      return {sq_if.alu_start, sq_if.opnd_a, sq_if.opnd_b, sq_if.op_sel, sq_if.mode,
              sq_if.disp_val, sq_if.disp_neg, sq_if.busy, sq_if.err};
   endfunction

   task automatic key(input logic [3:0] code);
      @(negedge clk);
      sq_if.key_valid = 1'b1;
      sq_if.key_code  = code;
      @(negedge clk);
      sq_if.key_valid = 1'b0;
      sq_if.key_code  = 4'd0;
   endtask

   task automatic alu_pulse(input logic [13:0] res, input logic neg);
      @(negedge clk);
      sq_if.alu_done   = 1'b1;
      sq_if.alu_result = res;
      sq_if.alu_neg    = neg;
      @(negedge clk);
      sq_if.alu_done   = 1'b0;
      sq_if.alu_result = 14'd0;
      sq_if.alu_neg    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sq_if.key_valid = 1'b0; sq_if.key_code = 4'd0;
      sq_if.alu_done = 1'b0; sq_if.alu_result = 14'd0; sq_if.alu_neg = 1'b0;
      idle(2);
      checks++; if (all_outs() !== 38'd0) begin errors++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
      rst_n = 1'b1;
      idle(1);
      checks++; if (all_outs() !== 38'd0) begin errors++; $display("FAIL post_reset_outs: got %h want 0", all_outs()); end
   endtask

   task automatic test_basic();
      key(4'd4);
      checks++; if (sq_if.opnd_a !== 7'd4 || sq_if.disp_val !== 14'd4) begin errors++; $display("FAIL digit4: opnd_a %0d disp %0d want 4", sq_if.opnd_a, sq_if.disp_val); end
      key(4'd2);
      checks++; if (sq_if.opnd_a !== 7'd42 || sq_if.mode !== 2'd0) begin errors++; $display("FAIL opnd_a42: opnd_a %0d mode %0d want 42/0", sq_if.opnd_a, sq_if.mode); end
      key(4'd10);
      checks++; if (sq_if.mode !== 2'd1 || sq_if.op_sel !== 2'd0 || sq_if.opnd_b !== 7'd0) begin errors++; $display("FAIL op_add: mode %0d op %0d b %0d want 1/0/0", sq_if.mode, sq_if.op_sel, sq_if.opnd_b); end
      key(4'd7);
      checks++; if (sq_if.opnd_b !== 7'd7 || sq_if.disp_val !== 14'd7 || sq_if.alu_start !== 1'b0) begin errors++; $display("FAIL opnd_b7: b %0d disp %0d start %0b want 7/7/0", sq_if.opnd_b, sq_if.disp_val, sq_if.alu_start); end
      key(4'd13);
      checks++; if (sq_if.alu_start !== 1'b1 || sq_if.mode !== 2'd2 || sq_if.busy !== 1'b1) begin errors++; $display("FAIL enter_exec: start %0b mode %0d busy %0b want 1/2/1", sq_if.alu_start, sq_if.mode, sq_if.busy); end
      idle(1);
      checks++; if (sq_if.alu_start !== 1'b0 || sq_if.disp_val !== 14'd7) begin errors++; $display("FAIL start_pulse_width: start %0b disp %0d want 0/7", sq_if.alu_start, sq_if.disp_val); end
      idle(1);
      alu_pulse(14'd49, 1'b0);
      checks++; if (sq_if.mode !== 2'd3 || sq_if.disp_val !== 14'd49 || sq_if.disp_neg !== 1'b0 || sq_if.busy !== 1'b0) begin errors++; $display("FAIL show49: mode %0d disp %0d neg %0b busy %0b want 3/49/0/0", sq_if.mode, sq_if.disp_val, sq_if.disp_neg, sq_if.busy); end
      checks++; if (sq_if.opnd_a !== 7'd42 || sq_if.opnd_b !== 7'd7 || sq_if.op_sel !== 2'd0) begin errors++; $display("FAIL operands_held: a %0d b %0d op %0d want 42/7/0", sq_if.opnd_a, sq_if.opnd_b, sq_if.op_sel); end
   endtask

   task automatic test_digit_limit();
      key(4'd14);
      checks++; if (all_outs() !== 38'd0) begin errors++; $display("FAIL show_clear: got %h want 0", all_outs()); end
      key(4'd1); key(4'd2); key(4'd3);
      checks++; if (sq_if.opnd_a !== 7'd12) begin errors++; $display("FAIL third_digit_drop: opnd_a %0d want 12", sq_if.opnd_a); end
      key(4'd11);
      checks++; if (sq_if.op_sel !== 2'd1 || sq_if.mode !== 2'd1) begin errors++; $display("FAIL op_sub: op %0d mode %0d want 1/1", sq_if.op_sel, sq_if.mode); end
      key(4'd12);
      checks++; if (sq_if.op_sel !== 2'd2 || sq_if.mode !== 2'd1 || sq_if.opnd_a !== 7'd12) begin errors++; $display("FAIL op_replace: op %0d mode %0d a %0d want 2/1/12", sq_if.op_sel, sq_if.mode, sq_if.opnd_a); end
   endtask

   task automatic test_negative();
      key(4'd14);
      checks++; if (sq_if.mode !== 2'd0 || sq_if.op_sel !== 2'd0 || sq_if.opnd_a !== 7'd0) begin errors++; $display("FAIL b_clear: mode %0d op %0d a %0d want 0/0/0", sq_if.mode, sq_if.op_sel, sq_if.opnd_a); end
      key(4'd5); key(4'd11); key(4'd9); key(4'd13);
      alu_pulse(14'd4, 1'b1);
      checks++; if (sq_if.mode !== 2'd3 || sq_if.disp_val !== 14'd4 || sq_if.disp_neg !== 1'b1) begin errors++; $display("FAIL show_neg: mode %0d disp %0d neg %0b want 3/4/1", sq_if.mode, sq_if.disp_val, sq_if.disp_neg); end
      key(4'd10);
      checks++; if (sq_if.mode !== 2'd3 || sq_if.disp_val !== 14'd4) begin errors++; $display("FAIL neg_chain_ignored: mode %0d disp %0d want 3/4", sq_if.mode, sq_if.disp_val); end
      key(4'd3);
      checks++; if (sq_if.mode !== 2'd0 || sq_if.opnd_a !== 7'd3 || sq_if.opnd_b !== 7'd0 || sq_if.disp_neg !== 1'b0) begin errors++; $display("FAIL show_digit: mode %0d a %0d b %0d neg %0b want 0/3/0/0", sq_if.mode, sq_if.opnd_a, sq_if.opnd_b, sq_if.disp_neg); end
      key(4'd8);
      checks++; if (sq_if.opnd_a !== 7'd38) begin errors++; $display("FAIL show_digit_count1: a %0d want 38", sq_if.opnd_a); end
   endtask

   task automatic test_chain();
      key(4'd14);
      key(4'd1); key(4'd5); key(4'd10); key(4'd1); key(4'd5); key(4'd13);
      alu_pulse(14'd30, 1'b0);
      checks++; if (sq_if.mode !== 2'd3 || sq_if.disp_val !== 14'd30) begin errors++; $display("FAIL show30: mode %0d disp %0d want 3/30", sq_if.mode, sq_if.disp_val); end
      key(4'd15);
      key(4'd13);
      checks++; if (sq_if.mode !== 2'd3 || sq_if.disp_val !== 14'd30 || sq_if.alu_start !== 1'b0) begin errors++; $display("FAIL show_ignore_15_13: mode %0d disp %0d start %0b want 3/30/0", sq_if.mode, sq_if.disp_val, sq_if.alu_start); end
      key(4'd12);
      checks++; if (sq_if.mode !== 2'd1 || sq_if.opnd_a !== 7'd30 || sq_if.op_sel !== 2'd2 || sq_if.opnd_b !== 7'd0) begin errors++; $display("FAIL chain_op: mode %0d a %0d op %0d b %0d want 1/30/2/0", sq_if.mode, sq_if.opnd_a, sq_if.op_sel, sq_if.opnd_b); end
      key(4'd3);
      checks++; if (sq_if.opnd_b !== 7'd3 || sq_if.opnd_a !== 7'd30) begin errors++; $display("FAIL chain_b: b %0d a %0d want 3/30", sq_if.opnd_b, sq_if.opnd_a); end
      key(4'd13);
      checks++; if (sq_if.alu_start !== 1'b1 || sq_if.mode !== 2'd2) begin errors++; $display("FAIL chain_start: start %0b mode %0d want 1/2", sq_if.alu_start, sq_if.mode); end
      alu_pulse(14'd90, 1'b0);
      checks++; if (sq_if.mode !== 2'd3 || sq_if.disp_val !== 14'd90) begin errors++; $display("FAIL show90: mode %0d disp %0d want 3/90", sq_if.mode, sq_if.disp_val); end
   endtask

   task automatic test_timeout();
      key(4'd14);
      key(4'd2); key(4'd10); key(4'd3); key(4'd13);
      idle(7);
      checks++; if (sq_if.mode !== 2'd2 || sq_if.busy !== 1'b1 || sq_if.err !== 1'b0) begin errors++; $display("FAIL pre_timeout: mode %0d busy %0b err %0b want 2/1/0", sq_if.mode, sq_if.busy, sq_if.err); end
      idle(1);
      checks++; if (sq_if.mode !== 2'd3 || sq_if.err !== 1'b1 || sq_if.disp_val !== 14'd0) begin errors++; $display("FAIL timeout: mode %0d err %0b disp %0d want 3/1/0", sq_if.mode, sq_if.err, sq_if.disp_val); end
      key(4'd14);
      checks++; if (sq_if.mode !== 2'd0 || sq_if.err !== 1'b0) begin errors++; $display("FAIL timeout_clear: mode %0d err %0b want 0/0", sq_if.mode, sq_if.err); end
      alu_pulse(14'd77, 1'b1);
      checks++; if (sq_if.mode !== 2'd0 || sq_if.disp_val !== 14'd0 || sq_if.disp_neg !== 1'b0) begin errors++; $display("FAIL done_outside_exec: mode %0d disp %0d neg %0b want 0/0/0", sq_if.mode, sq_if.disp_val, sq_if.disp_neg); end
   endtask

   task automatic test_clear_wins();
      key(4'd6); key(4'd10); key(4'd6); key(4'd13);
      key(4'd5);
      checks++; if (sq_if.mode !== 2'd2 || sq_if.opnd_b !== 7'd6) begin errors++; $display("FAIL exec_digit_ignored: mode %0d b %0d want 2/6", sq_if.mode, sq_if.opnd_b); end
      @(negedge clk);
      sq_if.key_valid = 1'b1; sq_if.key_code = 4'd14;
      sq_if.alu_done = 1'b1; sq_if.alu_result = 14'd36; sq_if.alu_neg = 1'b0;
      @(negedge clk);
      sq_if.key_valid = 1'b0; sq_if.key_code = 4'd0;
      sq_if.alu_done = 1'b0; sq_if.alu_result = 14'd0;
      checks++; if (all_outs() !== 38'd0) begin errors++; $display("FAIL clear_beats_done: got %h want 0", all_outs()); end
      alu_pulse(14'd36, 1'b0);
      checks++; if (sq_if.mode !== 2'd0 || sq_if.disp_val !== 14'd0) begin errors++; $display("FAIL late_done_ignored: mode %0d disp %0d want 0/0", sq_if.mode, sq_if.disp_val); end
   endtask

   task automatic test_reset_exec();
      key(4'd1); key(4'd10); key(4'd1); key(4'd13);
      checks++; if (sq_if.mode !== 2'd2) begin errors++; $display("FAIL reach_exec: mode %0d want 2", sq_if.mode); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (all_outs() !== 38'd0) begin errors++; $display("FAIL async_reset: got %h want 0", all_outs()); end
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      checks++; if (sq_if.alu_start !== 1'b0 || sq_if.mode !== 2'd0) begin errors++; $display("FAIL no_restart: start %0b mode %0d want 0/0", sq_if.alu_start, sq_if.mode); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_digit_limit();
      test_negative();
      test_chain();
      test_timeout();
      test_clear_wins();
      test_reset_exec();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Keypad-driven sequencer for the two-operand calculator datapath. It accumulates two decimal operands (0-99) and an operator from decoded key strobes. On Enter it launches the ALU with a start/done handshake, then latches and presents the result. It sits between the keypad decoder and the ALU/display mux, and supplies the mode code that drives the status LEDs.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in EXEC waiting for alu_done before error abort (1..65535)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  0-9 digit, 10 add, 11 sub, 12 mul, 13 enter, 14 clear, 15 unused
alu_done  in  1  one-cycle pulse, alu_result/alu_neg valid
alu_result  in  14  ALU result magnitude (0..9801)
alu_neg  in  1  ALU result sign (1 = negative)
alu_start  out  1  one-cycle launch pulse to ALU
opnd_a  out  7  operand A, binary 0..99
opnd_b  out  7  operand B, binary 0..99
op_sel  out  2  0 add, 1 sub, 2 mul
mode  out  2  0 ENTER_A, 1 ENTER_B, 2 EXEC, 3 SHOW
disp_val  out  14  value to display
disp_neg  out  1  display sign
busy  out  1  high in EXEC
err  out  1  sticky timeout flag, cleared by key 14 or a new digit

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs and registers go to 0; state ENTER_A.
- All outputs are registered. A key sampled at edge N is reflected after edge N. alu_start is high for exactly the one cycle after Enter is sampled.
- Digit entry (ENTER_A into opnd_a, ENTER_B into opnd_b): per-operand digit count 0..2. At count 0 or 1, new = old*10 + digit and count increments. At count 2, further digits are ignored (no wrap). A leading 0 counts as a digit.
- ENTER_A:
  - digit -> accumulate.
  - operator 10/11/12 -> latch op_sel, clear opnd_b and its count, go to ENTER_B.
  - enter -> ignored.
  - clear -> opnd_a = 0, count = 0, err = 0.
- ENTER_B:
  - digit -> accumulate.
  - operator -> replace op_sel, operands unchanged.
  - enter -> pulse alu_start, clear the timeout counter, go to EXEC.
  - clear -> full clear (both operands, op_sel = 0, err = 0), go to ENTER_A.
- EXEC:
  - busy = 1; opnd_a, opnd_b and op_sel are frozen.
  - Keys other than 14 are ignored.
  - alu_done -> latch alu_result/alu_neg into the result registers, go to SHOW.
  - Counter reaching TIMEOUT_CYCLES without alu_done -> err = 1, result = 0, go to SHOW.
  - Key 14 -> abort, full clear, go to ENTER_A. A later alu_done is ignored.
  - Key 14 and alu_done in the same cycle: clear wins.
- SHOW:
  - Digit -> full clear, then that digit becomes the first digit of opnd_a (count 1); go to ENTER_A; err = 0.
  - Operator -> if result is non-negative and <= 99: opnd_a = result, count_a = 2, latch op_sel, clear opnd_b, go to ENTER_B. Otherwise ignored.
  - Enter -> ignored.
  - Clear -> full clear, go to ENTER_A.
- alu_done outside EXEC: ignored.
- key_valid with code 15: ignored in all states.
- disp_val / disp_neg by state:
  - ENTER_A: opnd_a, sign 0.
  - ENTER_B: opnd_b, sign 0.
  - EXEC: opnd_b, sign 0.
  - SHOW: latched result and sign.
- Reset asserted mid-EXEC: immediate return to the reset state; no alu_start is reissued.

Test Plan:
- Keys 4,2,10,7,13; alu_done after 3 cycles with result 49 -> alu_start single pulse one cycle after key 13; opnd_a=42, opnd_b=7, op_sel=0; mode goes 0,1,2,3; disp_val=49, disp_neg=0.
- Keys 1,2,3 in ENTER_A -> opnd_a=12 (third digit dropped). Keys 11,12 -> op_sel=2, mode=1.
- Keys 5,11,9,13; alu_done with result 4, alu_neg=1 -> SHOW, disp_val=4, disp_neg=1. Key 10 -> ignored, stays SHOW. Key 3 -> mode 0, opnd_a=3, opnd_b=0.
- Chain: SHOW with result 30. Key 12, key 3, key 13 -> opnd_a=30, op_sel=2, opnd_b=3, second alu_start pulse.
- Enter, then no alu_done for TIMEOUT_CYCLES (set to 8) -> err=1, mode=3, disp_val=0. Key 14 -> err=0, mode=0.
- Key 14 and alu_done in the same EXEC cycle -> mode=0, all outputs 0, result not latched. Separately, rst_n pulsed low mid-EXEC -> all outputs 0 asynchronously.
